// File: rtl/tone_gen.sv
// Eight-channel programmable tone generator.
// One time-multiplexed scanner steps each channel's divider and phase per tick.
module tone_gen #(
    parameter int N_CH     = 8,
    parameter int PRESCALE = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  ch0,
    output logic [7:0]  ch1,
    output logic [7:0]  ch2,
    output logic [7:0]  ch3,
    output logic [7:0]  ch4,
    output logic [7:0]  ch5,
    output logic [7:0]  ch6,
    output logic [7:0]  ch7
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state;
    logic [2:0]      idx;
    logic [PW-1:0]   pre;
    logic            tick;

    logic [15:0]     div   [8];
    logic [2:0]      ctrl  [8];
    logic [15:0]     cnt   [8];
    logic [7:0]      phase [8];
    logic [7:0]      lfsr  [8];
    logic [7:0]      out   [8];

    logic [2:0]      sel;
    logic            hit;
    logic            accept;

    logic            en;
    logic [1:0]      wave;
    logic [15:0]     n_cnt;
    logic [7:0]      n_phase;
    logic [7:0]      n_lfsr;
    logic [7:0]      n_out;
    logic [7:0]      p2;

    logic            unused_bits;

    assign unused_bits = ^{addr[31:6], addr[1:0], wstrb[3:2], wdata[31:16]};

    assign sel    = addr[4:2];
    assign hit    = (32'(sel) < 32'(N_CH));
    assign accept = valid && !ready;
    assign tick   = (pre == PW'(PRESCALE - 1));

    // Bus side: register file writes, one-cycle ack and registered read data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready <= 1'b0;
            rdata <= 32'h0;
            for (int i = 0; i < 8; i++) begin
                div[i]  <= 16'h0;
                ctrl[i] <= 3'h0;
            end
        end else begin
            ready <= accept;
            if (accept) begin
                if (!hit)
                    rdata <= 32'h0;
                else if (addr[5])
                    rdata <= {29'h0, ctrl[sel]};
                else
                    rdata <= {16'h0, div[sel]};
                if (hit && !addr[5]) begin
                    if (wstrb[0])
                        div[sel][7:0] <= wdata[7:0];
                    if (wstrb[1])
                        div[sel][15:8] <= wdata[15:8];
                end
                if (hit && addr[5] && wstrb[0])
                    ctrl[sel] <= wdata[2:0];
            end
        end
    end

    // Next divider/phase/noise/sample values for the channel under scan
    always_comb begin
        en      = ctrl[idx][2];
        wave    = ctrl[idx][1:0];
        n_cnt   = cnt[idx] + 16'd1;
        n_phase = phase[idx];
        n_lfsr  = lfsr[idx];
        if (!en) begin
            n_cnt   = 16'h0;
            n_phase = 8'h0;
            n_lfsr  = 8'h01;
        end else if (cnt[idx] >= div[idx]) begin
            n_cnt   = 16'h0;
            n_phase = phase[idx] + 8'd1;
            if (wave == 2'd3)
                n_lfsr = {1'b0, lfsr[idx][7:1]}
                       ^ (lfsr[idx][0] ? 8'hB8 : 8'h00);
        end
        p2 = {n_phase[6:0], 1'b0};
        unique case (wave)
            2'd0: n_out = n_phase[7] ? 8'hFF : 8'h00;
            2'd1: n_out = n_phase;
            2'd2: n_out = n_phase[7] ? ~p2 : p2;
            2'd3: n_out = n_lfsr;
        endcase
        if (!en)
            n_out = 8'h00;
    end

    // Prescaler and scanner: one channel updated per cycle after each tick
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            idx   <= 3'd0;
            pre   <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt[i]   <= 16'h0;
                phase[i] <= 8'h0;
                lfsr[i]  <= 8'h01;
                out[i]   <= 8'h0;
            end
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        state <= SCAN;
                        idx   <= 3'd0;
                    end
                end
                SCAN: begin
                    cnt[idx]   <= n_cnt;
                    phase[idx] <= n_phase;
                    lfsr[idx]  <= n_lfsr;
                    out[idx]   <= n_out;
                    if (idx == 3'(N_CH - 1))
                        state <= IDLE;
                    else
                        idx <= idx + 3'd1;
                end
            endcase
        end
    end

    assign ch0 = (N_CH > 0) ? out[0] : 8'h00;
    assign ch1 = (N_CH > 1) ? out[1] : 8'h00;
    assign ch2 = (N_CH > 2) ? out[2] : 8'h00;
    assign ch3 = (N_CH > 3) ? out[3] : 8'h00;
    assign ch4 = (N_CH > 4) ? out[4] : 8'h00;
    assign ch5 = (N_CH > 5) ? out[5] : 8'h00;
    assign ch6 = (N_CH > 6) ? out[6] : 8'h00;
    assign ch7 = (N_CH > 7) ? out[7] : 8'h00;

endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen: cycle-count reference model plus directed literal checks.
// Four active channels, prescale 16.
module tb_tone_gen;

    localparam int N_CH = 4;
    localparam int P    = 16;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        valid  = 1'b0;
    logic [3:0]  wstrb  = 4'h0;
    logic [31:0] addr   = 32'h0;
    logic [31:0] wdata  = 32'h0;
    logic        ready;
    logic [31:0] rdata;
    logic [7:0]  ch0, ch1, ch2, ch3, ch4, ch5, ch6, ch7;
    logic [7:0]  chs [8];

    int tests = 0;
    int fails = 0;
    bit cmp_on = 1'b0;

    tone_gen #(.N_CH(N_CH), .PRESCALE(P)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .ready(ready),
        .wstrb(wstrb), .addr(addr), .wdata(wdata), .rdata(rdata),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .ch4(ch4), .ch5(ch5), .ch6(ch6), .ch7(ch7)
    );

    always #5 clk = ~clk;

    always_comb begin
        chs[0] = ch0; chs[1] = ch1; chs[2] = ch2; chs[3] = ch3;
        chs[4] = ch4; chs[5] = ch5; chs[6] = ch6; chs[7] = ch7;
    end

    // Reference model: cycles since reset release decide which channel is scanned
    logic [15:0] m_div   [8];
    logic [2:0]  m_ctrl  [8];
    int          m_cnt   [8];
    logic [7:0]  m_phase [8];
    logic [7:0]  m_lfsr  [8];
    logic [7:0]  m_out   [8];
    logic        m_ready;
    logic [31:0] m_rdata;
    int          mcyc;

    function automatic logic [7:0] shape(logic [1:0] w, logic [7:0] ph,
                                         logic [7:0] lf);
        int p;
        p = int'(ph);
        case (w)
            2'd0:    return (p >= 128) ? 8'hFF : 8'h00;
            2'd1:    return ph;
            2'd2:    return (p < 128) ? 8'(p * 2) : 8'(255 - (p - 128) * 2);
            default: return lf;
        endcase
    endfunction

    always @(posedge clk or negedge resetn) begin
        int k;
        int c;
        bit acc;
        if (!resetn) begin
            for (int i = 0; i < 8; i++) begin
                m_div[i] = 0; m_ctrl[i] = 0; m_cnt[i] = 0;
                m_phase[i] = 0; m_lfsr[i] = 8'h01; m_out[i] = 0;
            end
            m_ready = 0; m_rdata = 0; mcyc = 0;
        end else begin
            k = mcyc % P;
            if (mcyc >= P && k < N_CH) begin
                if (!m_ctrl[k][2]) begin
                    m_cnt[k] = 0; m_phase[k] = 0; m_lfsr[k] = 8'h01;
                    m_out[k] = 0;
                end else begin
                    if (m_cnt[k] >= int'(m_div[k])) begin
                        m_cnt[k] = 0;
                        m_phase[k] = 8'((int'(m_phase[k]) + 1) % 256);
                        if (m_ctrl[k][1:0] == 2'd3)
                            m_lfsr[k] = (m_lfsr[k] >> 1)
                                      ^ (m_lfsr[k][0] ? 8'hB8 : 8'h00);
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                    m_out[k] = shape(m_ctrl[k][1:0], m_phase[k], m_lfsr[k]);
                end
            end
            acc = valid && !m_ready;
            if (acc) begin
                c = int'(addr[4:2]);
                if (c >= N_CH) m_rdata = 0;
                else if (addr[5]) m_rdata = {29'h0, m_ctrl[c]};
                else m_rdata = {16'h0, m_div[c]};
                if (c < N_CH && !addr[5]) begin
                    if (wstrb[0]) m_div[c][7:0] = wdata[7:0];
                    if (wstrb[1]) m_div[c][15:8] = wdata[15:8];
                end
                if (c < N_CH && addr[5] && wstrb[0])
                    m_ctrl[c] = wdata[2:0];
            end
            m_ready = acc;
            mcyc = mcyc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every cycle: DUT outputs against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            check("ready", {31'h0, ready}, {31'h0, m_ready});
            check("rdata", rdata, m_rdata);
            for (int k = 0; k < 8; k++)
                check($sformatf("model_ch%0d", k), {24'h0, chs[k]},
                      {24'h0, m_out[k]});
        end
    end

    task automatic bus(input logic [3:0] s, input logic [2:0] c,
                       input logic r, input logic [31:0] d,
                       output logic [31:0] rd);
        @(negedge clk);
        check("ready_idle", {31'h0, ready}, 32'h0);
        valid = 1'b1; wstrb = s; addr = {26'h0, r, c, 2'b00}; wdata = d;
        @(negedge clk);
        check("ack", {31'h0, ready}, 32'h1);
        rd = rdata;
        valid = 1'b0; wstrb = 4'h0;
        @(negedge clk);
        check("ack_drop", {31'h0, ready}, 32'h0);
    endtask

    task automatic next_change(input int k, input int lim,
                               output logic [7:0] v, output int cy);
        logic [7:0] o;
        o = chs[k];
        cy = 0;
        do begin
            @(negedge clk);
            cy++;
        end while (chs[k] === o && cy < lim);
        v = chs[k];
    endtask

    task automatic wait_val(input int k, input logic [7:0] v, input int lim);
        int cy;
        cy = 0;
        while (chs[k] !== v && cy < lim) begin
            @(negedge clk);
            cy++;
        end
        check($sformatf("reach_ch%0d_%h", k, v), {24'h0, chs[k]},
              {24'h0, v});
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  v;
        logic [7:0]  noise_exp [4];
        int          cy;
        int          nz;

        noise_exp[0] = 8'hB8; noise_exp[1] = 8'h5C;
        noise_exp[2] = 8'h2E; noise_exp[3] = 8'h17;

        repeat (3) @(negedge clk);
        cmp_on = 1'b1;
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        for (int k = 0; k < 8; k++)
            check($sformatf("rst_ch%0d", k), {24'h0, chs[k]}, 32'h0);
        resetn = 1'b1;

        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 2; r++) begin
                bus(4'h0, 3'(c), 1'(r), 32'h0, rd);
                check($sformatf("rst_read_c%0d_r%0d", c, r), rd, 32'h0);
            end

        // Saw on ch0
        bus(4'h3, 3'd0, 1'b0, 32'h0, rd);
        bus(4'h1, 3'd0, 1'b1, 32'h5, rd);
        next_change(0, 40, v, cy);
        check("saw_first", {24'h0, v}, 32'h01);
        next_change(0, 40, v, cy);
        check("saw_second", {24'h0, v}, 32'h02);
        check("saw_period", cy, 16);
        next_change(0, 40, v, cy);
        check("saw_third", {24'h0, v}, 32'h03);

        // Square on ch1, triangle on ch2
        bus(4'h3, 3'd1, 1'b0, 32'h3, rd);
        bus(4'h1, 3'd1, 1'b1, 32'h4, rd);
        bus(4'h3, 3'd2, 1'b0, 32'h0, rd);
        bus(4'h1, 3'd2, 1'b1, 32'h6, rd);
        next_change(2, 40, v, cy);
        check("tri_first", {24'h0, v}, 32'h02);
        next_change(2, 40, v, cy);
        check("tri_second", {24'h0, v}, 32'h04);

        // Noise on ch3
        bus(4'h3, 3'd3, 1'b0, 32'h0, rd);
        bus(4'h1, 3'd3, 1'b1, 32'h7, rd);
        for (int i = 0; i < 4; i++) begin
            next_change(3, 40, v, cy);
            check($sformatf("noise_%0d", i), {24'h0, v},
                  {24'h0, noise_exp[i]});
        end

        wait_val(2, 8'hFF, 5000);
        wait_val(2, 8'h01, 5000);
        next_change(2, 40, v, cy);
        check("tri_wrap", {24'h0, v}, 32'h00);

        wait_val(0, 8'hFF, 5000);
        next_change(0, 40, v, cy);
        check("saw_wrap", {24'h0, v}, 32'h00);

        wait_val(1, 8'hFF, 10000);
        next_change(1, 9000, v, cy);
        check("square_low", {24'h0, v}, 32'h00);
        check("square_half", cy, 8192);

        // Unimplemented channel
        bus(4'h3, 3'd6, 1'b0, 32'h55AA, rd);
        bus(4'h0, 3'd6, 1'b0, 32'h0, rd);
        check("ch6_read", rd, 32'h0);
        check("ch6_out", {24'h0, ch6}, 32'h0);

        // High byte strobe only
        bus(4'h2, 3'd0, 1'b0, 32'h1234, rd);
        bus(4'h0, 3'd0, 1'b0, 32'h0, rd);
        check("div_hi_strobe", rd, 32'h1200);

        // Enable written in the same cycle ch3 is scanned
        bus(4'h1, 3'd3, 1'b1, 32'h0, rd);
        bus(4'h3, 3'd3, 1'b0, 32'h0, rd);
        while (mcyc % P != 3) @(negedge clk);
        valid = 1'b1; wstrb = 4'h1; addr = {26'h0, 1'b1, 3'd3, 2'b00};
        wdata = 32'h5;
        @(negedge clk);
        valid = 1'b0; wstrb = 4'h0;
        check("same_scan_ch3", {24'h0, ch3}, 32'h0);
        repeat (15) @(negedge clk);
        check("same_scan_hold", {24'h0, ch3}, 32'h0);
        @(negedge clk);
        check("same_scan_next", {24'h0, ch3}, 32'h01);

        // Reset during a scan cycle
        bus(4'h3, 3'd0, 1'b0, 32'h0, rd);
        repeat (40) @(negedge clk);
        while (mcyc % P != 2) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        for (int k = 0; k < 8; k++)
            check($sformatf("midrst_ch%0d", k), {24'h0, chs[k]}, 32'h0);
        check("midrst_ready", {31'h0, ready}, 32'h0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        nz = 0;
        repeat (300) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++)
                if (chs[k] !== 8'h0) nz++;
        end
        check("post_reset_quiet", nz, 0);

        // Random bus traffic
        repeat (400) begin
            logic [2:0]  c;
            logic        r;
            logic [3:0]  s;
            logic [31:0] d;
            repeat ($urandom_range(0, 4)) @(negedge clk);
            c = 3'($urandom_range(0, 7));
            r = 1'($urandom_range(0, 1));
            s = 4'($urandom_range(0, 3));
            d = r ? 32'($urandom_range(0, 7))
                  : {16'h0, 8'($urandom_range(0, 1)), 8'($urandom_range(0, 6))};
            bus(s, c, r, d, rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Eight-channel programmable tone generator that produces the 8-bit per-channel sample streams the mixer consumes on its ch0..ch7 inputs.
- Per channel, the CPU sets a 16-bit frequency divider and a control word (waveform and enable) over the simple valid/ready memory bus.
- A single time-multiplexed scanner advances every channel's divider counter and phase once per prescaler tick.

Parameters:
- N_CH, 8, number of active channels (1..8); ch outputs at or above N_CH are tied to 0.
- PRESCALE, 16, clk cycles per tick; must be >= N_CH + 1 (the scan must finish before the next tick).

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- valid  input  1  bus request
- ready  output  1  bus acknowledge
- wstrb  input  4  byte write strobes; all zero means read
- addr  input  32  byte address; [5] selects register, [4:2] selects channel
- wdata  input  32  write data
- rdata  output  32  read data, registered
- ch0..ch7  output  8 each  channel sample outputs, registered

Behaviour:
- Reset (async, resetn=0): ready=0, rdata=0, ch0..ch7=0; all DIV=0, CTRL=0, cnt=0, phase=0, lfsr=8'h01; prescaler=0; scanner IDLE.
- Register map, channel c=addr[4:2]:
  - addr[5]=0: DIV[15:0].
  - addr[5]=1: CTRL; [1:0] wave (0 square, 1 saw, 2 triangle, 3 noise), [2] enable.
- Bus handshake: an access is accepted when valid=1 and ready=0.
  - Next cycle: ready=1 for exactly one cycle; rdata holds the register value (zero-extended) sampled at acceptance.
  - Writes occur on the acceptance cycle. wstrb[0] writes DIV[7:0] or CTRL[2:0]; wstrb[1] writes DIV[15:8].
  - c >= N_CH: reads return 0, writes are ignored.
  - Back-to-back accesses: every other cycle at most.
- Prescaler: counts 0..PRESCALE-1 and wraps. The wrap cycle is a tick; the tick moves the scanner IDLE->SCAN with idx=0.
- SCAN processes channel idx on each cycle, then idx+1. After idx=N_CH-1 the scanner returns to IDLE. Per channel:
  - enable=0: cnt<=0, phase<=0, lfsr<=8'h01, chN<=0.
  - enable=1 and cnt >= DIV: cnt<=0 and phase<=phase+1, wrapping at 8 bits. For noise, the lfsr also steps: lfsr<={1'b0,lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00).
  - enable=1 otherwise: cnt<=cnt+1.
  - chN is updated from the new phase/lfsr:
    - square: phase[7] ? 8'hFF : 8'h00
    - saw: phase
    - triangle: phase[7] ? ~{phase[6:1+0],1'b0} using phase[6:0] : {phase[6:0],1'b0}. Exactly: p2={phase[6:0],1'b0}; out = phase[7] ? ~p2 : p2.
    - noise: lfsr
- Step rate: phase advances once every DIV+1 ticks. Output frequency = f_clk / (PRESCALE * (DIV+1) * 256).
- Outputs change only in the cycle their channel is scanned; outputs are held between scans.
- Simultaneous bus write and scan of the same channel: the scan uses the pre-write register values; the new value takes effect at the next scan.
- DIV lowered below the current cnt: at the next scan cnt >= DIV holds, so the channel steps and cnt clears. No long wrap occurs.
- Wave change mid-tone: phase is kept; only the output mapping changes at the next scan.
- resetn asserted mid-scan or mid-access: immediately returns everything to reset values. The aborted access receives no ready.

Test Plan:
- Reset check: hold resetn=0, then release. Required: all chN=0, ready=0 and rdata=0. Reads of DIV/CTRL for ch0..ch7 return 0, each read answered with a one-cycle ready the cycle after valid.
- Saw (PRESCALE=16): write DIV0=0, CTRL0=3'b101. Required: ch0 increments by 1 every 16 clk (1,2,3,...). After 256 ticks ch0 wraps 0xFF->0x00. Other channels stay 0.
- Square: DIV1=3, CTRL1=3'b100. Required: phase steps every 4 ticks; ch1=0x00 for 128 steps (512 ticks), then 0xFF for 512 ticks, repeating.
- Triangle/noise mapping: DIV=0, wave=2. Required: ch = 0x02, 0x04, ... 0xFE, then at phase 0x80 ch=0xFF, and at phase 0xFF ch=0x01. With wave=3, required ch sequence is 0xB8, 0x5C, 0x2E, 0x17, ...
- Bus edge cases (N_CH=4):
  - Write DIV at channel 6, then read it back: required 0, and ch6 stays 0.
  - Write DIV with wstrb=4'b0010, wdata=0x1234: required DIV=0x1200.
  - Write the enable bit of the channel being scanned in that same cycle: required the output changes only on the next scan.
- Mid-operation reset: with 4 channels running, pulse resetn low during a SCAN cycle. Required: chN=0 immediately, and after release no output changes until registers are rewritten.
